// File: rtl/half_subtractor.sv
// half_subtractor: registered, multi-lane half subtractor.
//
// Each lane computes d = a ^ b and bo = ~a & b. Both are registered on an
// accepted beat (in_valid=1) and held otherwise. out_valid marks the cycle
// that directly follows an accepted beat.
//
// Build option: define HALFSUB_BORROW_CNT_EN to compile in the saturating
// borrow counter and its borrow_cnt port. borrow_seen is always present.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   in_valid         input beat qualifier
//   a, b [WIDTH]     minuend / subtrahend bits, one per lane
//   clr              synchronous clear of borrow_seen / borrow_cnt (wins over a beat)
//   out_valid        d/bo hold the previous cycle's beat
//   d, bo [WIDTH]    registered difference / borrow per lane
//   borrow_seen      sticky: any lane borrow since reset or clr
//   borrow_cnt       saturating lane-borrow count (HALFSUB_BORROW_CNT_EN only)

module half_subtractor_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic bo_nxt,
  output logic d,
  output logic bo
);
  logic d_nxt;

  assign d_nxt  = a ^ b;
  assign bo_nxt = ~a & b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d  <= 1'b0;
      bo <= 1'b0;
    end else if (en) begin
      d  <= d_nxt;
      bo <= bo_nxt;
    end
  end
endmodule

module half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] bo,
`ifdef HALFSUB_BORROW_CNT_EN
  output logic             borrow_seen,
  output logic [CNT_W-1:0] borrow_cnt
`else
  output logic             borrow_seen
`endif
);
  localparam int STAGES = 1;

  logic [STAGES:0]  vld_pipe;
  logic [WIDTH-1:0] bo_nxt;
  logic             cnt_en;

  // Beat counts toward statistics only when clr is not asserted.
  assign cnt_en = in_valid & ~clr;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      half_subtractor_lane u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_valid),
        .a      (a[gi]),
        .b      (b[gi]),
        .bo_nxt (bo_nxt[gi]),
        .d      (d[gi]),
        .bo     (bo[gi])
      );
    end
  endgenerate

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 borrow_seen <= 1'b0;
    else if (clr)               borrow_seen <= 1'b0;
    else if (cnt_en && |bo_nxt) borrow_seen <= 1'b1;
  end

`ifdef HALFSUB_BORROW_CNT_EN
  localparam int PW    = $clog2(WIDTH + 1);
  // Sum is wide enough for the full count plus any popcount, so the
  // saturation compare never sees a wrapped value.
  localparam int SUM_W = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

  logic [PW-1:0]    pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(bo_nxt[i]);
  end

  always_comb begin
    sum     = SUM_W'(borrow_cnt) + SUM_W'(pop);
    cnt_nxt = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      borrow_cnt <= '0;
    else if (clr)    borrow_cnt <= '0;
    else if (cnt_en) borrow_cnt <= cnt_nxt;
  end
`endif
endmodule

// File: tb/tb_half_subtractor.sv
// Bench for half_subtractor. Two instances share clk/rst_n:
//   u4: WIDTH=4, CNT_W=16 (wide lanes, counter accumulation)
//   u1: WIDTH=1, CNT_W=2  (truth table, hold, saturation)
// Expected d/bo are queued when a beat is driven and popped when out_valid
// shows the result; borrow_seen/borrow_cnt follow a small reference model.
module tb_half_subtractor;
  logic clk, rst_n;
  logic       v1, a1, b1, clr1;
  logic [3:0] a4, b4;
  logic       v4, clr4;
  logic       ov1, d1, bo1, seen1;
  logic       ov4, seen4;
  logic [3:0] d4, bo4;
`ifdef HALFSUB_BORROW_CNT_EN
  logic [1:0]  cnt1;
  logic [15:0] cnt4;
`endif

  typedef struct { logic [3:0] d; logic [3:0] bo; } exp_t;
  exp_t q1[$];
  exp_t q4[$];
  int   m_cnt1, m_cnt4;
  logic m_seen1, m_seen4;
  int   n_vec = 0, n_err = 0;

  half_subtractor #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .clr(clr1),
    .out_valid(ov1), .d(d1), .bo(bo1),
`ifdef HALFSUB_BORROW_CNT_EN
    .borrow_seen(seen1), .borrow_cnt(cnt1)
`else
    .borrow_seen(seen1)
`endif
  );

  half_subtractor #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .clr(clr4),
    .out_valid(ov4), .d(d4), .bo(bo4),
`ifdef HALFSUB_BORROW_CNT_EN
    .borrow_seen(seen4), .borrow_cnt(cnt4)
`else
    .borrow_seen(seen4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue expectations and advance the reference model, then clock one edge.
  task automatic tick();
    exp_t e;
    logic [3:0] b4w;
    if (v1) begin e.d = {3'b0, a1 ^ b1}; e.bo = {3'b0, ~a1 & b1}; q1.push_back(e); end
    if (v4) begin e.d = a4 ^ b4; e.bo = ~a4 & b4; q4.push_back(e); end
    if (clr1) begin m_seen1 = 1'b0; m_cnt1 = 0; end
    else if (v1 && (~a1 & b1)) begin
      m_seen1 = 1'b1;
      m_cnt1  = (m_cnt1 + 1 > 3) ? 3 : m_cnt1 + 1;
    end
    b4w = ~a4 & b4;
    if (clr4) begin m_seen4 = 1'b0; m_cnt4 = 0; end
    else if (v4 && b4w != 0) begin
      m_seen4 = 1'b1;
      m_cnt4  = (m_cnt4 + $countones(b4w) > 65535) ? 65535 : m_cnt4 + $countones(b4w);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    v1 = 0; a1 = 0; b1 = 0; clr1 = 0;
    v4 = 0; a4 = 0; b4 = 0; clr4 = 0;
  endtask

  task automatic test_reset();
    // Mid-stream beats, then reset asserted between edges.
    v1 = 1; a1 = 1; b1 = 1; v4 = 1; a4 = 4'h0; b4 = 4'hF;
    tick();
    v1 = 1; a1 = 0; b1 = 1;
    rst_n = 0; #1;
    n_vec++; if ({ov1, d1, bo1, seen1} !== 4'b0) begin n_err++;
      $display("FAIL reset_u1: got ov/d/bo/seen=%b want 0000", {ov1, d1, bo1, seen1}); end
    n_vec++; if ({ov4, d4, bo4, seen4} !== 10'b0) begin n_err++;
      $display("FAIL reset_u4: got ov/d/bo/seen=%b want 0", {ov4, d4, bo4, seen4}); end
`ifdef HALFSUB_BORROW_CNT_EN
    n_vec++; if ({cnt1, cnt4} !== 18'b0) begin n_err++;
      $display("FAIL reset_cnt: got cnt1=%0d cnt4=%0d want 0", cnt1, cnt4); end
`endif
    q1.delete(); q4.delete();
    m_seen1 = 0; m_cnt1 = 0; m_seen4 = 0; m_cnt4 = 0;
    v4 = 0;
    @(posedge clk); #1;
    n_vec++; if (ov1 !== 1'b0) begin n_err++;
      $display("FAIL reset_hold: got out_valid=%b want 0", ov1); end
    rst_n = 1;
    // First beat after release: a=0,b=1 already on the inputs.
    tick();
    n_vec++;
    if (q1.size() == 0) begin n_err++; $display("FAIL post_reset: queue empty"); end
    else begin
      exp_t e = q1.pop_front();
      if ({ov1, d1, bo1} !== {1'b1, e.d[0], e.bo[0]}) begin n_err++;
        $display("FAIL post_reset: got ov/d/bo=%b want %b", {ov1, d1, bo1}, {1'b1, e.d[0], e.bo[0]}); end
    end
    idle_all();
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      v1 = 1; a1 = ab[1]; b1 = ab[0];
      tick();
      n_vec++;
      if (q1.size() == 0) begin n_err++; $display("FAIL truth_%0d: queue empty", i); end
      else begin
        exp_t e = q1.pop_front();
        if ({ov1, d1, bo1} !== {1'b1, e.d[0], e.bo[0]}) begin n_err++;
          $display("FAIL truth_%0d: got ov/d/bo=%b want %b", i, {ov1, d1, bo1}, {1'b1, e.d[0], e.bo[0]}); end
      end
      n_vec++; if (seen1 !== m_seen1) begin n_err++;
        $display("FAIL truth_seen_%0d: got %b want %b", i, seen1, m_seen1); end
    end
    idle_all();
  endtask

  task automatic test_hold();
    v1 = 1; a1 = 0; b1 = 1;
    tick();
    n_vec++;
    if (q1.size() == 0) begin n_err++; $display("FAIL hold_beat: queue empty"); end
    else begin
      exp_t e = q1.pop_front();
      if ({ov1, d1, bo1} !== {1'b1, e.d[0], e.bo[0]}) begin n_err++;
        $display("FAIL hold_beat: got ov/d/bo=%b want %b", {ov1, d1, bo1}, {1'b1, e.d[0], e.bo[0]}); end
    end
    v1 = 0; a1 = 1; b1 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if ({ov1, d1, bo1} !== 3'b011) begin n_err++;
        $display("FAIL hold_idle_%0d: got ov/d/bo=%b want 011", i, {ov1, d1, bo1}); end
    end
    idle_all();
  endtask

  task automatic test_wide();
    logic [3:0] av[2] = '{4'b0000, 4'b1010};
    logic [3:0] bv[2] = '{4'b1111, 4'b0101};
    int         cv[2] = '{4, 6};
    clr4 = 1; tick(); clr4 = 0;
    for (int i = 0; i < 2; i++) begin
      v4 = 1; a4 = av[i]; b4 = bv[i];
      tick();
      n_vec++;
      if (q4.size() == 0) begin n_err++; $display("FAIL wide_%0d: queue empty", i); end
      else begin
        exp_t e = q4.pop_front();
        if ({ov4, d4, bo4} !== {1'b1, e.d, e.bo}) begin n_err++;
          $display("FAIL wide_%0d: got ov/d/bo=%b want %b", i, {ov4, d4, bo4}, {1'b1, e.d, e.bo}); end
      end
      n_vec++; if (seen4 !== 1'b1) begin n_err++;
        $display("FAIL wide_seen_%0d: got %b want 1", i, seen4); end
`ifdef HALFSUB_BORROW_CNT_EN
      n_vec++; if (cnt4 !== 16'(cv[i])) begin n_err++;
        $display("FAIL wide_cnt_%0d: got %0d want %0d", i, cnt4, cv[i]); end
`else
      if (cv[i] < 0) $display("unused");
`endif
    end
    idle_all();
  endtask

  task automatic test_clr();
    v1 = 1; a1 = 0; b1 = 1; clr1 = 1;
    v4 = 1; a4 = 4'b0000; b4 = 4'b0110; clr4 = 1;
    tick();
    n_vec++; if ({ov1, bo1, seen1} !== 3'b110) begin n_err++;
      $display("FAIL clr_u1: got ov/bo/seen=%b want 110", {ov1, bo1, seen1}); end
    n_vec++; if ({ov4, bo4, seen4} !== 6'b1_0110_0) begin n_err++;
      $display("FAIL clr_u4: got ov/bo/seen=%b want 101100", {ov4, bo4, seen4}); end
`ifdef HALFSUB_BORROW_CNT_EN
    n_vec++; if ({cnt1, cnt4} !== 18'b0) begin n_err++;
      $display("FAIL clr_cnt: got cnt1=%0d cnt4=%0d want 0", cnt1, cnt4); end
`endif
    q1.delete(); q4.delete();
    idle_all();
  endtask

  task automatic test_saturation();
    int want[5] = '{1, 2, 3, 3, 3};
    clr1 = 1; tick(); clr1 = 0;
    for (int i = 0; i < 5; i++) begin
      v1 = 1; a1 = 0; b1 = 1;
      tick();
      void'(q1.pop_front());
      n_vec++; if (seen1 !== 1'b1) begin n_err++;
        $display("FAIL sat_seen_%0d: got %b want 1", i, seen1); end
`ifdef HALFSUB_BORROW_CNT_EN
      n_vec++; if (cnt1 !== 2'(want[i])) begin n_err++;
        $display("FAIL sat_cnt_%0d: got %0d want %0d", i, cnt1, want[i]); end
`else
      if (want[i] < 0) $display("unused");
`endif
    end
    idle_all();
  endtask

  task automatic test_random();
    exp_t last;
    last.d = d4; last.bo = bo4;
    for (int i = 0; i < 40; i++) begin
      v4 = 1'($urandom_range(0, 3) != 0);
      a4 = 4'($urandom); b4 = 4'($urandom);
      clr4 = 1'($urandom_range(0, 7) == 0);
      tick();
      if (v4) begin
        n_vec++;
        if (q4.size() == 0) begin n_err++; $display("FAIL rand_%0d: queue empty", i); end
        else begin
          last = q4.pop_front();
          if ({ov4, d4, bo4} !== {1'b1, last.d, last.bo}) begin n_err++;
            $display("FAIL rand_%0d: got ov/d/bo=%b want %b", i, {ov4, d4, bo4}, {1'b1, last.d, last.bo}); end
        end
      end else begin
        n_vec++; if ({ov4, d4, bo4} !== {1'b0, last.d, last.bo}) begin n_err++;
          $display("FAIL rand_idle_%0d: got ov/d/bo=%b want %b", i, {ov4, d4, bo4}, {1'b0, last.d, last.bo}); end
      end
      n_vec++; if (seen4 !== m_seen4) begin n_err++;
        $display("FAIL rand_seen_%0d: got %b want %b", i, seen4, m_seen4); end
`ifdef HALFSUB_BORROW_CNT_EN
      n_vec++; if (cnt4 !== 16'(m_cnt4)) begin n_err++;
        $display("FAIL rand_cnt_%0d: got %0d want %0d", i, cnt4, m_cnt4); end
`endif
    end
    idle_all();
  endtask

  initial begin
    rst_n = 0;
    idle_all();
    m_seen1 = 0; m_cnt1 = 0; m_seen4 = 0; m_cnt4 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_truth_table();
    test_hold();
    test_wide();
    test_clr();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
